simd_compare_pipe: RTL

- Parametrised multi-lane successor to the single-lane ALU comparator.
- Per lane: compares two operands under a selectable relation (EQ/NE/LT/LE/GT/GE) in signed or unsigned mode, using an internal subtract.
- Produces a per-lane predicate and a zero-extended per-lane result.
- Sits in the SIMD ALU datapath behind operand collection. Two-stage elastic pipeline with valid/ready handshake.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/cmp_lane.sv | 20 ++
 rtl/simd_compare_pipe.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU compare definitions: relation encoding and packed-lane slicing helper.
// Combinational only; no latency or backpressure of its own.
package alu_pkg;

  localparam int CMP_MODE_WIDTH = 3;

  typedef enum logic [CMP_MODE_WIDTH-1:0] {
    CMP_EQ    = 3'd0,
    CMP_NE    = 3'd1,
    CMP_LT    = 3'd2,
    CMP_LE    = 3'd3,
    CMP_GT    = 3'd4,
    CMP_GE    = 3'd5,
    CMP_RSVD6 = 3'd6,
    CMP_RSVD7 = 3'd7
  } cmp_mode_e;

  // LSB position of a lane inside a packed multi-lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/cmp_lane.sv
// Single-lane compare via (W+1)-bit extended subtract; combinational, zero latency,
// no handshake (pipeline and backpressure live in simd_compare_pipe).
module cmp_lane #(
  parameter int SRC_WIDTH = 32
) (
  input  logic [SRC_WIDTH-1:0] a,
  input  logic [SRC_WIDTH-1:0] b,
  input  logic                 is_signed,
  output logic                 lt,
  output logic                 eq
);

  logic [SRC_WIDTH:0] diff;

  // One extra bit keeps the difference exact, so its MSB is the true sign in both modes.
  assign diff = {is_signed & a[SRC_WIDTH-1], a} - {is_signed & b[SRC_WIDTH-1], b};
  assign lt   = diff[SRC_WIDTH];
  assign eq   = ~|diff;

endmodule

// File: rtl/simd_compare_pipe.sv
// Multi-lane EQ/NE/LT/LE/GT/GE compare, 2-cycle valid/ready pipeline at 1 beat/cycle;
// stages hold under out_ready=0 and in_ready drops once both are full. SIMD_COMPARE_REDUCE_EN adds pred_any/pred_all.
module simd_compare_pipe
  import alu_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int SRC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int MODE_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*SRC_WIDTH-1:0] src_a,
  input  logic [LANES*SRC_WIDTH-1:0] src_b,
  input  logic [MODE_WIDTH-1:0]      mode,
  input  logic                       is_signed,
  input  logic [LANES-1:0]           lane_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES-1:0]           pred,
  output logic [LANES*OUT_WIDTH-1:0] result
`ifdef SIMD_COMPARE_REDUCE_EN
  ,
  output logic                       pred_any,
  output logic                       pred_all
`endif
);

  logic                  s1_valid;
  logic [LANES-1:0]      s1_lt;
  logic [LANES-1:0]      s1_eq;
  logic [MODE_WIDTH-1:0] s1_mode;
  logic [LANES-1:0]      s1_en;
  logic                  s2_valid;
  logic                  s1_load;
  logic                  s2_load;
  logic [LANES-1:0]      lane_lt;
  logic [LANES-1:0]      lane_eq;
  logic [LANES-1:0]      rel;
  logic [LANES-1:0]      pred_next;

  assign s2_load   = ~s2_valid | out_ready;
  assign s1_load   = ~s1_valid | s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cmp_lane #(.SRC_WIDTH(SRC_WIDTH)) u_cmp_lane (
      .a         (src_a[lane_lsb(i, SRC_WIDTH) +: SRC_WIDTH]),
      .b         (src_b[lane_lsb(i, SRC_WIDTH) +: SRC_WIDTH]),
      .is_signed (is_signed),
      .lt        (lane_lt[i]),
      .eq        (lane_eq[i])
    );
    assign result[lane_lsb(i, OUT_WIDTH) +: OUT_WIDTH] = OUT_WIDTH'(pred[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lt    <= '0;
      s1_eq    <= '0;
      s1_mode  <= '0;
      s1_en    <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lt   <= lane_lt;
        s1_eq   <= lane_eq;
        s1_mode <= mode;
        s1_en   <= lane_en;
      end
    end
  end

  always_comb begin
    rel = '0;
    case (cmp_mode_e'(s1_mode))
      CMP_EQ:  rel = s1_eq;
      CMP_NE:  rel = ~s1_eq;
      CMP_LT:  rel = s1_lt;
      CMP_LE:  rel = s1_lt | s1_eq;
      CMP_GT:  rel = ~s1_lt & ~s1_eq;
      CMP_GE:  rel = ~s1_lt;
      default: rel = '0;
    endcase
    pred_next = rel & s1_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      pred     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        pred <= pred_next;
      end
    end
  end

`ifdef SIMD_COMPARE_REDUCE_EN
  // pred_next is already masked, so "all" means every enabled lane came through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_any <= 1'b0;
      pred_all <= 1'b0;
    end else if (s2_load && s1_valid) begin
      pred_any <= |pred_next;
      pred_all <= (|s1_en) & (pred_next == s1_en);
    end
  end
`endif

endmodule
